// File: rtl/result_wr_pkg.sv
// Shared constants and burst-length helper for the result write channel.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_wr_pkg;

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         LP_DW_BYTES   = 64;
  localparam int         LP_4K         = 4096;

  // Beats in the next burst: bounded by the configured maximum, by what is
  // left to issue, and by the room before the next 4 KB page boundary.
  function automatic logic [6:0] calc_blen(input logic [31:0] max_beats,
                                           input logic [31:0] remaining,
                                           input logic [11:0] page_off);
    logic [31:0] room;
    logic [31:0] b;
    room = (32'(LP_4K) - {20'd0, page_off}) / 32'(LP_DW_BYTES);
    b = max_beats;
    if (remaining < b) b = remaining;
    if (room < b) b = room;
    return 7'(b);
  endfunction

endpackage

// File: rtl/result_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Latency: a pushed word is visible on dout_o the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clk/rst_n (sync, active-low), push_i/din_i, pop_i/dout_o,
//        full_o, empty_o, count_o (occupancy, 0..DEPTH).
module result_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/result_write_channel.sv
// Buffers an AXI4-Stream of 64-byte result beats and writes them to host
// memory as 4 KB-safe AXI4 bursts, pulsing ctrl_done once all B responses return.
// Latency: first AW one cycle after the FIFO holds a full first burst; W follows AW.
// Backpressure: s_axis_tready drops when the FIFO is full or N beats were taken;
//   AW is throttled by buffered data and by C_MAX_OUTSTANDING unanswered bursts.
// Ports: ctrl_start/ctrl_done/status_error control, resultPtr and
//   result_xfer_size_in_bytes sampled at start, s_axis_* result stream in,
//   m_axi_aw*/w*/b* AXI4 write master out.
module result_write_channel
  import result_wr_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 64,
  parameter int C_MAX_OUTSTANDING  = 16,
  parameter int C_FIFO_DEPTH       = 128
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ctrl_start,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   resultPtr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    result_xfer_size_in_bytes,
  output logic                            status_error,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic [1:0]                      m_axi_bresp
);

  localparam int NB_W = C_XFER_SIZE_WIDTH - 6;          // beat-count width
  localparam int DC_W = $clog2(C_FIFO_DEPTH) + 1;       // data FIFO count width
  localparam int OC_W = $clog2(C_MAX_OUTSTANDING) + 1;  // outstanding width

  logic [1:0]                    state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, awaddr_q;
  logic [7:0]                    awlen_q;
  logic                          awvalid_q;
  logic [NB_W-1:0]               n_q, beats_in_q, beats_iss_q, beats_w_q;
  logic [OC_W-1:0]               outst_q;
  logic [6:0]                    wbeat_q;
  logic                          err_q, done_q;

  logic [NB_W-1:0]               n_size, committed, need;
  logic [6:0]                    blen, aw_beats;
  logic                          aw_go, aw_hs, w_hs, b_hs, s_hs, wlast;

  logic [C_M_AXI_DATA_WIDTH-1:0] data_dout;
  logic                          data_full, data_empty;
  logic [DC_W-1:0]               data_count;
  logic [6:0]                    wq_dout;
  logic                          wq_full, wq_empty;
  logic [OC_W-1:0]               wq_count;
  logic                          unused_bits;

  assign n_size = result_xfer_size_in_bytes[C_XFER_SIZE_WIDTH-1:6];

  // ---------------- stream side ----------------
  assign s_axis_tready = (state_q == ST_RUN) && !data_full && (beats_in_q < n_q);
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  // ---------------- AW issue ----------------
  assign blen      = calc_blen(32'(C_BURST_LEN), 32'(n_q - beats_iss_q), addr_q[11:0]);
  // Beats already promised to issued bursts still sit in the FIFO; the next
  // burst may only be issued once its own data is buffered on top of those.
  assign committed = beats_iss_q - beats_w_q;
  assign need      = committed + NB_W'(blen);
  assign aw_go     = (state_q == ST_RUN) && !awvalid_q && (beats_iss_q != n_q) &&
                     (NB_W'(data_count) >= need) &&
                     (outst_q < OC_W'(C_MAX_OUTSTANDING)) && !wq_full;
  assign aw_hs     = awvalid_q && m_axi_awready;
  assign aw_beats  = awlen_q[6:0] + 7'd1;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;

  // ---------------- W channel ----------------
  assign m_axi_wvalid = !wq_empty && !data_empty;
  assign m_axi_wdata  = data_dout;
  assign m_axi_wstrb  = '1;
  assign wlast        = m_axi_wvalid && ((wbeat_q + 7'd1) == wq_dout);
  assign m_axi_wlast  = wlast;
  assign w_hs         = m_axi_wvalid && m_axi_wready;

  // ---------------- B channel ----------------
  assign m_axi_bready = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign b_hs         = m_axi_bvalid && m_axi_bready;

  assign ctrl_done    = done_q;
  assign status_error = err_q;
  assign unused_bits  = ^{result_xfer_size_in_bytes[5:0], s_axis_tlast, wq_count};

  result_wr_fifo #(.WIDTH(C_M_AXI_DATA_WIDTH), .DEPTH(C_FIFO_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_hs),
    .din_i   (s_axis_tdata),
    .pop_i   (w_hs),
    .dout_o  (data_dout),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_count)
  );

  // Burst lengths of issued AWs, consumed by the W side in issue order.
  result_wr_fifo #(.WIDTH(7), .DEPTH(C_MAX_OUTSTANDING)) u_wlen_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (aw_hs),
    .din_i   (aw_beats),
    .pop_i   (w_hs && wlast),
    .dout_o  (wq_dout),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .count_o (wq_count)
  );

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ctrl_start) state_d = (n_size == '0) ? ST_FINISH : ST_RUN;
      ST_RUN:    if ((beats_w_q == n_q) && (beats_iss_q == n_q)) state_d = ST_DRAIN;
      ST_DRAIN:  if (outst_q == '0) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      n_q         <= '0;
      beats_in_q  <= '0;
      beats_iss_q <= '0;
      beats_w_q   <= '0;
      outst_q     <= '0;
      wbeat_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FINISH);

      if ((state_q == ST_IDLE) && ctrl_start) begin
        addr_q      <= resultPtr;
        n_q         <= n_size;
        beats_in_q  <= '0;
        beats_iss_q <= '0;
        beats_w_q   <= '0;
        wbeat_q     <= '0;
        err_q       <= 1'b0;
      end else begin
        if (s_hs) beats_in_q <= beats_in_q + NB_W'(1);

        // awaddr/awlen are captured once and held until the handshake.
        if (aw_go) begin
          awvalid_q <= 1'b1;
          awaddr_q  <= addr_q;
          awlen_q   <= 8'(blen - 7'd1);
        end
        if (aw_hs) begin
          awvalid_q   <= 1'b0;
          addr_q      <= addr_q + (C_M_AXI_ADDR_WIDTH'(aw_beats) << 6);
          beats_iss_q <= beats_iss_q + NB_W'(aw_beats);
        end

        if (w_hs) begin
          beats_w_q <= beats_w_q + NB_W'(1);
          wbeat_q   <= wlast ? 7'd0 : wbeat_q + 7'd1;
        end

        if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
      end

      case ({aw_hs, b_hs})
        2'b10:   outst_q <= outst_q + OC_W'(1);
        2'b01:   outst_q <= outst_q - OC_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: tb/tb_result_write_channel.sv
// Directed bench for result_write_channel with a simple AXI slave/stream model.
// Latency: n/a.
// Backpressure: optional AW/W ready toggling and a B-channel hold.
module tb_result_write_channel;

  logic         clk;
  logic         rst_n;
  logic         ctrl_start;
  logic         ctrl_done;
  logic [63:0]  resultPtr;
  logic [31:0]  result_xfer_size_in_bytes;
  logic         status_error;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid;
  logic         m_axi_bready;
  logic [1:0]   m_axi_bresp;

  result_write_channel dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .ctrl_start                (ctrl_start),
    .ctrl_done                 (ctrl_done),
    .resultPtr                 (resultPtr),
    .result_xfer_size_in_bytes (result_xfer_size_in_bytes),
    .status_error              (status_error),
    .s_axis_tvalid             (s_axis_tvalid),
    .s_axis_tready             (s_axis_tready),
    .s_axis_tdata              (s_axis_tdata),
    .s_axis_tlast              (s_axis_tlast),
    .m_axi_awvalid             (m_axi_awvalid),
    .m_axi_awready             (m_axi_awready),
    .m_axi_awaddr              (m_axi_awaddr),
    .m_axi_awlen               (m_axi_awlen),
    .m_axi_wvalid              (m_axi_wvalid),
    .m_axi_wready              (m_axi_wready),
    .m_axi_wdata               (m_axi_wdata),
    .m_axi_wstrb               (m_axi_wstrb),
    .m_axi_wlast               (m_axi_wlast),
    .m_axi_bvalid              (m_axi_bvalid),
    .m_axi_bready              (m_axi_bready),
    .m_axi_bresp               (m_axi_bresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int t, input int i);
    return {16{8'(t), 24'(i)}};
  endfunction

  // Stream source / AXI slave state, all updated by the model process.
  int          cyc = 0;
  int          tid = 0;
  int          s_idx = 0, s_total = 0;
  int          w_cnt = 0, aw_cnt = 0, wl_cnt = 0, b_cnt = 0;
  int          err_b = -1;
  bit          b_en = 1'b1;
  bit          rdy_mode = 1'b0;
  int          wdata_err = 0;
  int          done_cnt = 0;
  logic [63:0] aw_addr_q[$];
  int          aw_len_q[$];
  int          wlast_at[$];

  // Drive on the falling edge, then look at the settled outputs 1 ns later
  // to record the handshakes that the next rising edge will complete.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      s_axis_tvalid = (s_idx < s_total);
      s_axis_tdata  = pat(tid, s_idx);
      s_axis_tlast  = 1'b0;
      m_axi_awready = rdy_mode ? cyc[0] : 1'b1;
      m_axi_wready  = rdy_mode ? ((cyc % 3) != 0) : 1'b1;
      m_axi_bvalid  = b_en && (((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) > b_cnt);
      m_axi_bresp   = (b_cnt == err_b) ? 2'b10 : 2'b00;
      #1;
      if (s_axis_tvalid && s_axis_tready) s_idx++;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(int'(m_axi_awlen));
        aw_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wdata !== pat(tid, w_cnt) || m_axi_wstrb !== '1) wdata_err++;
        w_cnt++;
        if (m_axi_wlast) begin
          wlast_at.push_back(w_cnt);
          wl_cnt++;
        end
      end
      if (m_axi_bvalid && m_axi_bready) b_cnt++;
      if (ctrl_done) done_cnt++;
    end
  end

  task automatic start_xfer(input logic [63:0] ptr, input int size, input int extra);
    @(negedge clk); #3;
    s_idx = 0; s_total = size / 64 + extra;
    w_cnt = 0; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; wdata_err = 0; done_cnt = 0;
    aw_addr_q.delete(); aw_len_q.delete(); wlast_at.delete();
    resultPtr = ptr;
    result_xfer_size_in_bytes = 32'(size);
    ctrl_start = 1'b1;
    @(negedge clk); #3;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk); #2;
      if (ctrl_done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_wcnt(input int target, input int max_cyc, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk); #2;
      if (w_cnt >= target) got = 1'b1;
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ctrl_start = 1'b0;
    resultPtr = '0;
    result_xfer_size_in_bytes = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready,
                           ctrl_done, status_error}), 64'd0);
    #1 rst_n = 1'b1;

    // 1: single short burst; extra stream beats must be refused
    tid = 1;
    start_xfer(64'h1000, 192, 4);
    wait_done(300, "t1");
    chk("t1_b_before_done", 64'(b_cnt), 64'd1);
    settle();
    chk("t1_aw_cnt", 64'(aw_cnt), 64'd1);
    chk("t1_aw0_addr", aw_addr_q[0], 64'h1000);
    chk("t1_aw0_len", 64'(aw_len_q[0]), 64'd2);
    chk("t1_w_cnt", 64'(w_cnt), 64'd3);
    chk("t1_wlast0", 64'(wlast_at[0]), 64'd3);
    chk("t1_wlast_cnt", 64'(wl_cnt), 64'd1);
    chk("t1_wdata_err", 64'(wdata_err), 64'd0);
    chk("t1_stream_taken", 64'(s_idx), 64'd3);
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);
    chk("t1_error", 64'(status_error), 64'd0);

    // 2: 100 beats, split at the max burst length, with AW/W backpressure
    tid = 2;
    rdy_mode = 1'b1;
    start_xfer(64'h0, 6400, 3);
    wait_done(2000, "t2");
    settle();
    rdy_mode = 1'b0;
    chk("t2_aw_cnt", 64'(aw_cnt), 64'd2);
    chk("t2_aw0_addr", aw_addr_q[0], 64'h0);
    chk("t2_aw0_len", 64'(aw_len_q[0]), 64'd63);
    chk("t2_aw1_addr", aw_addr_q[1], 64'h1000);
    chk("t2_aw1_len", 64'(aw_len_q[1]), 64'd35);
    chk("t2_wlast0", 64'(wlast_at[0]), 64'd64);
    chk("t2_wlast1", 64'(wlast_at[1]), 64'd100);
    chk("t2_w_cnt", 64'(w_cnt), 64'd100);
    chk("t2_wdata_err", 64'(wdata_err), 64'd0);
    chk("t2_stream_taken", 64'(s_idx), 64'd100);
    chk("t2_done_pulses", 64'(done_cnt), 64'd1);

    // 3: 4 KB boundary split
    tid = 3;
    start_xfer(64'h0FC0, 256, 0);
    wait_done(300, "t3");
    settle();
    chk("t3_aw_cnt", 64'(aw_cnt), 64'd2);
    chk("t3_aw0_addr", aw_addr_q[0], 64'h0FC0);
    chk("t3_aw0_len", 64'(aw_len_q[0]), 64'd0);
    chk("t3_aw1_addr", aw_addr_q[1], 64'h1000);
    chk("t3_aw1_len", 64'(aw_len_q[1]), 64'd2);
    chk("t3_wlast0", 64'(wlast_at[0]), 64'd1);
    chk("t3_wlast1", 64'(wlast_at[1]), 64'd4);
    chk("t3_wdata_err", 64'(wdata_err), 64'd0);

    // 4: outstanding limit with B held off
    tid = 4;
    b_en = 1'b0;
    start_xfer(64'h0, 17 * 4096, 0);
    wait_wcnt(1024, 4000, "t4_w16_bursts");
    repeat (100) @(negedge clk);
    #2;
    chk("t4_aw_cnt_held", 64'(aw_cnt), 64'd16);
    chk("t4_awvalid_low", 64'(m_axi_awvalid), 64'd0);
    chk("t4_w_cnt_held", 64'(w_cnt), 64'd1024);
    #1 b_en = 1'b1;
    wait_done(1000, "t4");
    settle();
    chk("t4_aw_cnt", 64'(aw_cnt), 64'd17);
    chk("t4_aw16_addr", aw_addr_q[16], 64'h10000);
    chk("t4_aw16_len", 64'(aw_len_q[16]), 64'd63);
    chk("t4_w_cnt", 64'(w_cnt), 64'd1088);
    chk("t4_b_cnt", 64'(b_cnt), 64'd17);
    chk("t4_wdata_err", 64'(wdata_err), 64'd0);

    // 5: SLVERR on second of three bursts
    tid = 5;
    err_b = 1;
    start_xfer(64'h0, 3 * 4096, 0);
    wait_done(1000, "t5");
    chk("t5_error_at_done", 64'(status_error), 64'd1);
    settle();
    err_b = -1;
    chk("t5_error_sticky", 64'(status_error), 64'd1);
    chk("t5_aw_cnt", 64'(aw_cnt), 64'd3);

    // 6: zero-length transfer; done exactly two cycles after start
    @(negedge clk); #3;
    s_total = 0; aw_cnt = 0; w_cnt = 0;
    aw_addr_q.delete(); aw_len_q.delete(); wlast_at.delete();
    resultPtr = 64'h3000;
    result_xfer_size_in_bytes = 32'd0;
    ctrl_start = 1'b1;
    @(negedge clk); #2;
    chk("t6_error_cleared", 64'(status_error), 64'd0);
    chk("t6_done_c1", 64'(ctrl_done), 64'd0);
    #1 ctrl_start = 1'b0;
    @(negedge clk); #2;
    chk("t6_done_c2", 64'(ctrl_done), 64'd1);
    @(negedge clk); #2;
    chk("t6_done_c3", 64'(ctrl_done), 64'd0);
    chk("t6_aw_cnt", 64'(aw_cnt), 64'd0);

    // 7: reset in the middle of RUN, then a clean transfer
    tid = 7;
    start_xfer(64'h0, 6400, 0);
    wait_wcnt(10, 500, "t7_w_started");
    @(negedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("t7_rst_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                            s_axis_tready, ctrl_done, status_error}), 64'd0);
    #1 rst_n = 1'b1;
    tid = 8;
    start_xfer(64'h2000, 192, 0);
    wait_done(300, "t8");
    settle();
    chk("t8_aw0_addr", aw_addr_q[0], 64'h2000);
    chk("t8_w_cnt", 64'(w_cnt), 64'd3);
    chk("t8_wdata_err", 64'(wdata_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
